// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Owns the fetch PC and the IF/ID pipeline register. It holds the front
//   end while the hazard unit asserts its active-low stall, and it inserts
//   bubbles into ID/EX during that time. On an EX-stage redirect (taken
//   branch, jal or jalr) it squashes the fetched instructions. It also keeps
//   saturating stall and flush counters and a sticky stuck-stall watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   RUN   | normal fetch; the PC advances every edge
//   HOLD  | the last edge stalled; the next edge with stall=1 advances again
//   FLUSH | squash window after a redirect; stall is ignored and not counted
//
// Ports
//   clk             in   1      clock, rising edge
//   rst_n           in   1      asynchronous reset, active-low
//   stall           in   1      active-low: 0 = hold the front end
//   redirect        in   1      EX redirect request
//   redirect_pc     in   32     redirect target
//   imem_instr      in   32     instruction at pc (combinational fetch)
//   compressed_flag in   1      imem_instr is a 16-bit RVC instruction
//   pc              out  32     current fetch PC
//   if_id_instr     out  32     IF/ID instruction
//   if_id_pc        out  32     IF/ID PC
//   if_id_valid     out  1      IF/ID holds a real instruction
//   id_ex_bubble    out  1      zero the ID/EX control signals
//   stall_cnt       out  CNT_W  stalled cycles, saturating
//   flush_cnt       out  CNT_W  accepted redirects, saturating
//   stall_timeout   out  1      sticky watchdog flag
module pipeline_stall_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16,
  parameter int          MAX_STALL    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      imem_instr,
  input  logic             compressed_flag,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic             if_id_valid,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int          WD_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [FL_W-1:0]  flush_left, flush_left_nxt;
  logic [WD_W-1:0]  consec, consec_nxt;
  logic [31:0]      pc_nxt, if_id_instr_nxt, if_id_pc_nxt;
  logic             if_id_valid_nxt, id_ex_bubble_nxt, stall_timeout_nxt;
  logic [CNT_W-1:0] stall_cnt_nxt, flush_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      flush_left    <= '0;
      consec        <= '0;
      pc            <= RESET_PC;
      if_id_instr   <= NOP;
      if_id_pc      <= '0;
      if_id_valid   <= 1'b0;
      id_ex_bubble  <= 1'b1;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      flush_left    <= flush_left_nxt;
      consec        <= consec_nxt;
      pc            <= pc_nxt;
      if_id_instr   <= if_id_instr_nxt;
      if_id_pc      <= if_id_pc_nxt;
      if_id_valid   <= if_id_valid_nxt;
      id_ex_bubble  <= id_ex_bubble_nxt;
      stall_cnt     <= stall_cnt_nxt;
      flush_cnt     <= flush_cnt_nxt;
      stall_timeout <= stall_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    flush_left_nxt    = flush_left;
    consec_nxt        = consec;
    pc_nxt            = pc;
    if_id_instr_nxt   = if_id_instr;
    if_id_pc_nxt      = if_id_pc;
    if_id_valid_nxt   = if_id_valid;
    id_ex_bubble_nxt  = id_ex_bubble;
    stall_cnt_nxt     = stall_cnt;
    flush_cnt_nxt     = flush_cnt;
    stall_timeout_nxt = stall_timeout;

    if (redirect) begin
      pc_nxt           = redirect_pc;
      if_id_instr_nxt  = NOP;
      if_id_pc_nxt     = '0;
      if_id_valid_nxt  = 1'b0;
      id_ex_bubble_nxt = 1'b1;
      consec_nxt       = '0;
      if (!(&flush_cnt))
        flush_cnt_nxt = flush_cnt + 1'b1;
      // The redirect edge itself is the first squash cycle, so only the
      // remaining FLUSH_CYCLES-1 cycles are spent in FLUSH.
      if (FLUSH_CYCLES > 1) begin
        state_nxt      = FLUSH;
        flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
      end else begin
        state_nxt      = RUN;
        flush_left_nxt = '0;
      end
    end else if (state == FLUSH) begin
      if_id_instr_nxt  = NOP;
      if_id_pc_nxt     = '0;
      if_id_valid_nxt  = 1'b0;
      id_ex_bubble_nxt = 1'b1;
      if (flush_left <= FL_W'(1)) begin
        state_nxt      = RUN;
        flush_left_nxt = '0;
      end else begin
        flush_left_nxt = flush_left - 1'b1;
      end
    end else if (!stall) begin
      state_nxt        = HOLD;
      id_ex_bubble_nxt = 1'b1;
      if (!(&stall_cnt))
        stall_cnt_nxt = stall_cnt + 1'b1;
      // The watchdog count parks at MAX_STALL so it can never wrap back
      // below the trip point during a very long stall.
      if (consec != WD_W'(MAX_STALL))
        consec_nxt = consec + 1'b1;
      if (consec_nxt == WD_W'(MAX_STALL))
        stall_timeout_nxt = 1'b1;
    end else begin
      state_nxt        = RUN;
      pc_nxt           = pc + (compressed_flag ? 32'd2 : 32'd4);
      if_id_instr_nxt  = imem_instr;
      if_id_pc_nxt     = pc;
      if_id_valid_nxt  = 1'b1;
      id_ex_bubble_nxt = 1'b0;
      consec_nxt       = '0;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, compressed_flag;
  logic [31:0] redirect_pc, imem_instr;

  always #5 clk = ~clk;

  // a: default parameters, b: FLUSH_CYCLES=3, c: CNT_W=4 / MAX_STALL=5
  logic [31:0] a_pc, a_instr, a_ifpc, b_pc, b_instr, b_ifpc, c_pc, c_instr, c_ifpc;
  logic        a_valid, a_bub, a_to, b_valid, b_bub, b_to, c_valid, c_bub, c_to;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  logic [3:0]  c_sc, c_fc;

  pipeline_stall_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_instr(imem_instr), .compressed_flag(compressed_flag),
    .pc(a_pc), .if_id_instr(a_instr), .if_id_pc(a_ifpc), .if_id_valid(a_valid),
    .id_ex_bubble(a_bub), .stall_cnt(a_sc), .flush_cnt(a_fc), .stall_timeout(a_to));

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_instr(imem_instr), .compressed_flag(compressed_flag),
    .pc(b_pc), .if_id_instr(b_instr), .if_id_pc(b_ifpc), .if_id_valid(b_valid),
    .id_ex_bubble(b_bub), .stall_cnt(b_sc), .flush_cnt(b_fc), .stall_timeout(b_to));

  pipeline_stall_ctrl #(.CNT_W(4), .MAX_STALL(5)) u_c (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_instr(imem_instr), .compressed_flag(compressed_flag),
    .pc(c_pc), .if_id_instr(c_instr), .if_id_pc(c_ifpc), .if_id_valid(c_valid),
    .id_ex_bubble(c_bub), .stall_cnt(c_sc), .flush_cnt(c_fc), .stall_timeout(c_to));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] instr;
    logic        c;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic [31:0] e_instr;
    logic        e_val;
    logic        e_bub;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vec[14];

  initial begin
    rst_n = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_instr = '0; compressed_flag = 1'b0;

    //        st  rd  rpc           instr         c     pc            ifpc          instr         val   bub   sc  fc
    vec[0]  = '{1'b1,1'b0,32'h0,        32'h0000_0AAA,1'b0, 32'h4,        32'h0,        32'h0000_0AAA,1'b1, 1'b0, 0, 0};
    vec[1]  = '{1'b1,1'b0,32'h0,        32'h0000_0BBB,1'b1, 32'h6,        32'h4,        32'h0000_0BBB,1'b1, 1'b0, 0, 0};
    vec[2]  = '{1'b1,1'b0,32'h0,        32'h0000_0CCC,1'b0, 32'hA,        32'h6,        32'h0000_0CCC,1'b1, 1'b0, 0, 0};
    vec[3]  = '{1'b1,1'b1,32'h1C,       32'h0000_0FFF,1'b0, 32'h1C,       32'h0,        32'h13,       1'b0, 1'b1, 0, 1};
    vec[4]  = '{1'b1,1'b0,32'h0,        32'h0000_0DDD,1'b0, 32'h20,       32'h1C,       32'h0000_0DDD,1'b1, 1'b0, 0, 1};
    vec[5]  = '{1'b0,1'b0,32'h0,        32'h0000_0EEE,1'b0, 32'h20,       32'h1C,       32'h0000_0DDD,1'b1, 1'b1, 1, 1};
    vec[6]  = '{1'b0,1'b0,32'h0,        32'h0000_0EEE,1'b0, 32'h20,       32'h1C,       32'h0000_0DDD,1'b1, 1'b1, 2, 1};
    vec[7]  = '{1'b1,1'b0,32'h0,        32'h0000_0EEE,1'b0, 32'h24,       32'h20,       32'h0000_0EEE,1'b1, 1'b0, 2, 1};
    vec[8]  = '{1'b0,1'b0,32'h0,        32'h0000_0111,1'b0, 32'h24,       32'h20,       32'h0000_0EEE,1'b1, 1'b1, 3, 1};
    vec[9]  = '{1'b0,1'b1,32'h100,      32'h0000_0111,1'b0, 32'h100,      32'h0,        32'h13,       1'b0, 1'b1, 3, 2};
    vec[10] = '{1'b1,1'b0,32'h0,        32'h0000_0222,1'b1, 32'h102,      32'h100,      32'h0000_0222,1'b1, 1'b0, 3, 2};
    vec[11] = '{1'b1,1'b1,32'hFFFF_FFFC,32'h0000_0333,1'b0, 32'hFFFF_FFFC,32'h0,        32'h13,       1'b0, 1'b1, 3, 3};
    vec[12] = '{1'b1,1'b0,32'h0,        32'h0000_0444,1'b0, 32'h0,        32'hFFFF_FFFC,32'h0000_0444,1'b1, 1'b0, 3, 3};
    vec[13] = '{1'b1,1'b0,32'h0,        32'h0000_0077,1'b0, 32'h4,        32'h0,        32'h0000_0077,1'b1, 1'b0, 3, 3};

    repeat (2) step();
    check("rst_pc", a_pc, 32'h0);
    check("rst_instr", a_instr, 32'h13);
    check("rst_ifpc", a_ifpc, 32'h0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_bubble", 32'(a_bub), 32'd1);
    check("rst_stall_cnt", 32'(a_sc), 32'd0);
    check("rst_flush_cnt", 32'(a_fc), 32'd0);
    check("rst_timeout", 32'(a_to), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      stall = vec[i].st; redirect = vec[i].rd; redirect_pc = vec[i].rpc;
      imem_instr = vec[i].instr; compressed_flag = vec[i].c;
      step();
      check($sformatf("v%0d_pc", i), a_pc, vec[i].e_pc);
      check($sformatf("v%0d_instr", i), a_instr, vec[i].e_instr);
      if (vec[i].e_val)
        check($sformatf("v%0d_ifpc", i), a_ifpc, vec[i].e_ifpc);
      check($sformatf("v%0d_valid", i), 32'(a_valid), 32'(vec[i].e_val));
      check($sformatf("v%0d_bubble", i), 32'(a_bub), 32'(vec[i].e_bub));
      check($sformatf("v%0d_stall_cnt", i), 32'(a_sc), 32'(vec[i].e_sc));
      check($sformatf("v%0d_flush_cnt", i), 32'(a_fc), 32'(vec[i].e_fc));
    end

    // asynchronous reset in the middle of a cycle
    stall = 1'b1; redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", a_pc, 32'h0);
    check("async_instr", a_instr, 32'h13);
    check("async_valid", 32'(a_valid), 32'd0);
    check("async_bubble", 32'(a_bub), 32'd1);
    check("async_flush_cnt", 32'(a_fc), 32'd0);
    step();
    rst_n = 1'b1;

    // three-cycle flush window, stall ignored inside it
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    check("fl_pc", b_pc, 32'h40);
    check("fl_valid", 32'(b_valid), 32'd0);
    check("fl_flush_cnt", 32'(b_fc), 32'd1);
    redirect = 1'b0; stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("fl_hold%0d_pc", k), b_pc, 32'h40);
      check($sformatf("fl_hold%0d_valid", k), 32'(b_valid), 32'd0);
      check($sformatf("fl_hold%0d_bubble", k), 32'(b_bub), 32'd1);
      check($sformatf("fl_hold%0d_instr", k), b_instr, 32'h13);
      check($sformatf("fl_hold%0d_stall_cnt", k), 32'(b_sc), 32'd0);
    end
    stall = 1'b1; imem_instr = 32'h0000_1234; compressed_flag = 1'b0;
    step();
    check("fl_end_valid", 32'(b_valid), 32'd1);
    check("fl_end_ifpc", b_ifpc, 32'h40);
    check("fl_end_instr", b_instr, 32'h0000_1234);
    check("fl_end_pc", b_pc, 32'h44);
    check("fl_end_bubble", 32'(b_bub), 32'd0);

    // redirect arriving inside FLUSH restarts the countdown
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_pc = 32'h90;
    step();
    check("refl_pc", b_pc, 32'h90);
    check("refl_flush_cnt", 32'(b_fc), 32'd3);
    redirect = 1'b0; imem_instr = 32'h0000_5678;
    repeat (2) step();
    check("refl_still_flush", 32'(b_valid), 32'd0);
    check("refl_hold_pc", b_pc, 32'h90);
    step();
    check("refl_fetch_valid", 32'(b_valid), 32'd1);
    check("refl_fetch_ifpc", b_ifpc, 32'h90);

    // saturation and watchdog on the narrow instance
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    stall = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 4) check("wd_edge4", 32'(c_to), 32'd0);
      if (k == 5) check("wd_edge5", 32'(c_to), 32'd1);
    end
    check("sat_stall_cnt", 32'(c_sc), 32'd15);
    check("sat_pc", c_pc, 32'h0);
    stall = 1'b1; compressed_flag = 1'b0;
    step();
    check("wd_sticky", 32'(c_to), 32'd1);
    check("wd_resume_pc", c_pc, 32'h4);
    check("wd_resume_cnt", 32'(c_sc), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
